// File: rtl/apb_slave_regs.sv
// ---------------------------------------------------------------------------
// apb_slave_regs
//
// APB target for one select line of the AHB-to-APB bridge. Two-phase
// SETUP/ACCESS transfers are decoded into a word-addressed register bank.
// Read data is sampled at the SETUP edge, so it is stable on Prdata
// throughout the ACCESS cycle. Completed transfers are counted, and any
// sequencing violation seen from the initiator side sets a sticky error flag.
//
// Parameters:
//   SEL_INDEX : bit of Pselx that selects this block (0..2)
//   ADDR_BASE : byte address of register 0
//   NUM_REGS  : number of 32-bit registers (power of two, 2..256)
//   ID_VALUE  : constant returned by register 0 (read-only)
//
// Ports:
//   clk       in   1  clock, all state on the rising edge
//   rst       in   1  asynchronous active-low reset
//   Pselx     in   3  bridge slave selects, only bit SEL_INDEX is used
//   Paddr     in  32  byte address (bits [1:0] ignored)
//   Pwrite    in   1  1 = write, 0 = read
//   Penable   in   1  ACCESS phase indicator
//   Pwdata    in  32  write data
//   Prdata    out 32  registered read data
//   wr_count  out 16  completed writes, wraps
//   rd_count  out 16  completed reads, wraps
//   oob_count out  8  completed out-of-window transfers, saturates at 255
//   prot_err  out  1  sticky protocol-violation flag
// ---------------------------------------------------------------------------
module apb_slave_regs #(
  parameter int unsigned SEL_INDEX = 0,
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned NUM_REGS  = 16,
  parameter logic [31:0] ID_VALUE  = 32'hA5B0_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  Pselx,
  input  logic [31:0] Paddr,
  input  logic        Pwrite,
  input  logic        Penable,
  input  logic [31:0] Pwdata,
  output logic [31:0] Prdata,
  output logic [15:0] wr_count,
  output logic [15:0] rd_count,
  output logic [7:0]  oob_count,
  output logic        prot_err
);

  localparam int unsigned IDX_W     = $clog2(NUM_REGS);
  localparam logic [31:0] WIN_BYTES = 32'(NUM_REGS * 4);

  typedef enum logic {
    IDLE    = 1'b0,
    ACC_EXP = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [31:0] lat_addr;
  logic        lat_write;

  // Register 0 is the constant ID, so only 1..NUM_REGS-1 need storage.
  logic [31:0] regs [1:NUM_REGS-1];

  logic             sel;
  logic [31:0]      offset;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic [31:0]      rd_val;

  logic do_setup;
  logic do_done;
  logic err_set;

  // Bits that intentionally play no part in decoding.
  logic unused_bits;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // -------------------------------------------------------------------------
  // Address decode
  // -------------------------------------------------------------------------
  // An address below ADDR_BASE wraps to a large offset and therefore falls
  // outside the window, so a single unsigned compare covers both sides.
  assign sel         = Pselx[SEL_INDEX];
  assign offset      = Paddr - ADDR_BASE;
  assign in_range    = (offset < WIN_BYTES);
  assign idx         = offset[IDX_W+1:2];
  assign unused_bits = ^{Pselx, offset[1:0]};

  always_comb begin
    rd_val = '0;
    if (in_range) begin
      rd_val = (idx == '0) ? ID_VALUE : regs[idx];
    end
  end

  // -------------------------------------------------------------------------
  // Transfer sequencing FSM
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    do_setup = 1'b0;
    do_done  = 1'b0;
    err_set  = 1'b0;
    case (state_q)
      IDLE: begin
        if (sel) begin
          if (!Penable) begin
            do_setup = 1'b1;
            state_d  = ACC_EXP;
          end else begin
            // ACCESS without a preceding SETUP.
            err_set = 1'b1;
          end
        end
      end
      ACC_EXP: begin
        if (!sel) begin
          err_set = 1'b1;
          state_d = IDLE;
        end else if (!Penable) begin
          // Previous SETUP abandoned; this cycle is a fresh SETUP.
          err_set  = 1'b1;
          do_setup = 1'b1;
        end else begin
          state_d = IDLE;
          if ((Paddr == lat_addr) && (Pwrite == lat_write)) begin
            do_done = 1'b1;
          end else begin
            err_set = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Setup latch, read data, counters and error flag
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_addr  <= '0;
      lat_write <= 1'b0;
      Prdata    <= '0;
      wr_count  <= '0;
      rd_count  <= '0;
      oob_count <= '0;
      prot_err  <= 1'b0;
    end else begin
      if (do_setup) begin
        lat_addr  <= Paddr;
        lat_write <= Pwrite;
        if (!Pwrite) begin
          Prdata <= rd_val;
        end
      end
      if (do_done) begin
        if (lat_write) begin
          wr_count <= wr_count + 16'd1;
        end else begin
          rd_count <= rd_count + 16'd1;
        end
        if (!in_range) begin
          oob_count <= sat_inc8(oob_count);
        end
      end
      if (err_set) begin
        prot_err <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Register bank
  // -------------------------------------------------------------------------
  // Paddr equals lat_addr whenever do_done is set, so the live decode is
  // the latched address at the completing edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (do_done && lat_write && in_range && (idx != '0)) begin
      regs[idx] <= Pwdata;
    end
  end

endmodule

// File: tb/tb_apb_slave_regs.sv
module tb_apb_slave_regs;

  logic        clk;
  logic        rst;
  logic [2:0]  pselx;
  logic [31:0] paddr;
  logic        pwrite;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic [15:0] wr_count;
  logic [15:0] rd_count;
  logic [7:0]  oob_count;
  logic        prot_err;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam logic [31:0] ID   = 32'hA5B0_0001;

  apb_slave_regs dut (
    .clk       (clk),
    .rst       (rst),
    .Pselx     (pselx),
    .Paddr     (paddr),
    .Pwrite    (pwrite),
    .Penable   (penable),
    .Pwdata    (pwdata),
    .Prdata    (prdata),
    .wr_count  (wr_count),
    .rd_count  (rd_count),
    .oob_count (oob_count),
    .prot_err  (prot_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // All bus tasks start and end 1 time unit after a rising edge.
  task automatic do_reset();
    pselx   = 3'b000;
    penable = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [31:0] a, input logic [31:0] d);
    pselx   = 3'b001;
    paddr   = a;
    pwrite  = 1'b1;
    pwdata  = d;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(posedge clk);
    #1;
    pselx   = 3'b000;
    penable = 1'b0;
  endtask

  task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
    pselx   = 3'b001;
    paddr   = a;
    pwrite  = 1'b0;
    penable = 1'b0;
    @(posedge clk);
    #1 penable = 1'b1;
    @(negedge clk);
    d = prdata;
    @(posedge clk);
    #1;
    pselx   = 3'b000;
    penable = 1'b0;
  endtask

  logic [31:0] r;

  initial begin
    rst = 1'b0; pselx = '0; paddr = '0; pwrite = 1'b0; penable = 1'b0; pwdata = '0;
    #12;
    check("rst_prdata", prdata, 32'h0);
    check("rst_wr", 32'(wr_count), 32'h0);
    check("rst_rd", 32'(rd_count), 32'h0);
    check("rst_oob", 32'(oob_count), 32'h0);
    check("rst_err", 32'(prot_err), 32'h0);
    do_reset();

    // Other select bits must be ignored.
    pselx = 3'b110; paddr = BASE; pwrite = 1'b1; pwdata = 32'h5555_5555; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    @(posedge clk); #1 pselx = 3'b000; penable = 1'b0;
    check("othsel_wr", 32'(wr_count), 32'h0);
    check("othsel_err", 32'(prot_err), 32'h0);

    // ID register read.
    apb_read(BASE, r);
    check("id_read", r, ID);
    check("id_rd_count", 32'(rd_count), 32'h1);
    check("id_err", 32'(prot_err), 32'h0);

    // Write then back-to-back read.
    do_reset();
    apb_write(BASE + 32'h8, 32'h1234_5678);
    apb_read(BASE + 32'h8, r);
    check("rw_data", r, 32'h1234_5678);
    check("rw_wr", 32'(wr_count), 32'h1);
    check("rw_rd", 32'(rd_count), 32'h1);
    apb_read(BASE + 32'hC, r);
    check("rw_neighbour", r, 32'h0);
    check("rw_err", 32'(prot_err), 32'h0);

    // Writes to register 0 are counted but ignored.
    do_reset();
    apb_write(BASE, 32'hFFFF_FFFF);
    apb_read(BASE, r);
    check("ro_data", r, ID);
    check("ro_wr", 32'(wr_count), 32'h1);

    // Window boundaries and out-of-range accesses.
    do_reset();
    apb_write(BASE + 32'h3C, 32'hCAFE_F00D);
    apb_read(BASE + 32'h3F, r);
    check("last_reg_lowbits", r, 32'hCAFE_F00D);
    apb_read(BASE + 32'h40, r);
    check("oob_read", r, 32'h0);
    check("oob_cnt1", 32'(oob_count), 32'h1);
    check("oob_rd", 32'(rd_count), 32'h2);
    apb_write(BASE + 32'h44, 32'h7777_7777);
    check("oob_prdata_hold", prdata, 32'h0);
    apb_write(BASE - 32'h4, 32'h7777_7777);
    check("oob_cnt3", 32'(oob_count), 32'h3);
    check("oob_wr", 32'(wr_count), 32'h3);
    apb_read(BASE + 32'h3C, r);
    check("oob_no_alias", r, 32'hCAFE_F00D);
    apb_read(BASE + 32'h4, r);
    check("oob_reg1", r, 32'h0);
    check("oob_err", 32'(prot_err), 32'h0);

    // Penable on two consecutive selected cycles with no SETUP.
    do_reset();
    pselx = 3'b001; paddr = BASE + 32'h4; pwrite = 1'b1; pwdata = 32'h1111_1111; penable = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1 pselx = 3'b000; penable = 1'b0;
    check("dblen_err", 32'(prot_err), 32'h1);
    check("dblen_wr", 32'(wr_count), 32'h0);
    apb_read(BASE + 32'h4, r);
    check("dblen_reg", r, 32'h0);

    // Address changed between SETUP and ACCESS.
    do_reset();
    pselx = 3'b001; paddr = BASE + 32'h4; pwrite = 1'b1; pwdata = 32'h2222_2222; penable = 1'b0;
    @(posedge clk); #1 paddr = BASE + 32'h8; penable = 1'b1;
    @(posedge clk); #1 pselx = 3'b000; penable = 1'b0;
    check("amis_err", 32'(prot_err), 32'h1);
    check("amis_wr", 32'(wr_count), 32'h0);
    apb_read(BASE + 32'h4, r);
    check("amis_reg4", r, 32'h0);
    apb_read(BASE + 32'h8, r);
    check("amis_reg8", r, 32'h0);

    // SETUP dropped without ACCESS.
    do_reset();
    pselx = 3'b001; paddr = BASE + 32'h4; pwrite = 1'b1; pwdata = 32'h3333_3333; penable = 1'b0;
    @(posedge clk); #1 pselx = 3'b000;
    @(posedge clk); #1;
    check("drop_err", 32'(prot_err), 32'h1);
    check("drop_wr", 32'(wr_count), 32'h0);

    // Reset asserted during the ACCESS cycle of a write.
    do_reset();
    apb_write(BASE + 32'hC, 32'h0000_0005);
    apb_read(BASE, r);
    pselx = 3'b001; penable = 1'b1;
    @(posedge clk); #1 pselx = 3'b000; penable = 1'b0;
    check("pre_rst_err", 32'(prot_err), 32'h1);
    pselx = 3'b001; paddr = BASE + 32'h4; pwrite = 1'b1; pwdata = 32'hDEAD_BEEF; penable = 1'b0;
    @(posedge clk); #1 penable = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("mid_rst_prdata", prdata, 32'h0);
    check("mid_rst_wr", 32'(wr_count), 32'h0);
    check("mid_rst_rd", 32'(rd_count), 32'h0);
    check("mid_rst_err", 32'(prot_err), 32'h0);
    @(posedge clk); #1 pselx = 3'b000; penable = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    apb_read(BASE + 32'h4, r);
    check("post_rst_reg4", r, 32'h0);
    apb_read(BASE + 32'hC, r);
    check("post_rst_regC", r, 32'h0);
    check("post_rst_rd", 32'(rd_count), 32'h2);
    check("post_rst_wr", 32'(wr_count), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
